// File: rtl/multiplier.sv
// Sequential shift-add multiplier with a strobe/acknowledge handshake on both sides.
// Define MULTIPLIER_SIGNED_EN for two's-complement operands and product; unsigned by default.
module multiplier #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [A_WIDTH-1:0]         I_DAT_A,
  input  logic [B_WIDTH-1:0]         I_DAT_B,
  input  logic                       I_STB,
  output logic                       I_ACK,
  output logic [A_WIDTH+B_WIDTH-1:0] O_DAT,
  output logic                       O_STB,
  input  logic                       O_ACK
);

  localparam int P_WIDTH   = A_WIDTH + B_WIDTH;
  localparam int CNT_WIDTH = $clog2(B_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(B_WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [P_WIDTH-1:0]   a_q, a_d;
  logic [B_WIDTH-1:0]   b_q, b_d;
  logic [P_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ack_q, ack_d;
  logic                 stb_q, stb_d;
  logic [P_WIDTH-1:0]   dat_q, dat_d;

  logic [A_WIDTH-1:0]   a_mag;
  logic [B_WIDTH-1:0]   b_mag;
  logic [P_WIDTH-1:0]   result;

`ifdef MULTIPLIER_SIGNED_EN
  logic neg_q;

  // The datapath works on magnitudes; the product sign is reapplied once at the end.
  assign a_mag  = I_DAT_A[A_WIDTH-1] ? (~I_DAT_A + A_WIDTH'(1)) : I_DAT_A;
  assign b_mag  = I_DAT_B[B_WIDTH-1] ? (~I_DAT_B + B_WIDTH'(1)) : I_DAT_B;
  assign result = neg_q ? (~acc_q + P_WIDTH'(1)) : acc_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      neg_q <= 1'b0;
    end else if (state_q == IDLE && I_STB) begin
      neg_q <= I_DAT_A[A_WIDTH-1] ^ I_DAT_B[B_WIDTH-1];
    end
  end
`else
  assign a_mag  = I_DAT_A;
  assign b_mag  = I_DAT_B;
  assign result = acc_q;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    stb_d   = stb_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        if (I_STB) begin
          a_d     = P_WIDTH'(a_mag);
          b_d     = b_mag;
          acc_d   = '0;
          cnt_d   = '0;
          ack_d   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // One bit of B per cycle; the extra cycle after the last bit publishes the result.
        if (cnt_q == CNT_LAST) begin
          dat_d   = result;
          stb_d   = 1'b1;
          state_d = DONE;
        end else begin
          if (b_q[0]) begin
            acc_d = acc_q + a_q;
          end
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      DONE: begin
        if (O_ACK) begin
          stb_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
      dat_q   <= dat_d;
    end
  end

  assign I_ACK = ack_q;
  assign O_STB = stb_q;
  assign O_DAT = dat_q;

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for multiplier (16x16): directed vectors, decoupled result monitor.
module tb_multiplier;
  localparam int AW = 16;
  localparam int BW = 16;

`ifdef MULTIPLIER_SIGNED_EN
  localparam logic [31:0] EXP_FF  = 32'h0000_0001;
  localparam logic [31:0] EXP_NEG = 32'hFFFF_FFEB;
`else
  localparam logic [31:0] EXP_FF  = 32'hFFFE_0001;
  localparam logic [31:0] EXP_NEG = 32'h0006_FFEB;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [AW-1:0] I_DAT_A = '0;
  logic [BW-1:0] I_DAT_B = '0;
  logic          I_STB = 1'b0;
  logic          I_ACK;
  logic [31:0]   O_DAT;
  logic          O_STB;
  logic          O_ACK = 1'b0;

  multiplier #(.A_WIDTH(AW), .B_WIDTH(BW)) dut (
    .CLK(CLK), .RST(RST), .I_DAT_A(I_DAT_A), .I_DAT_B(I_DAT_B), .I_STB(I_STB),
    .I_ACK(I_ACK), .O_DAT(O_DAT), .O_STB(O_STB), .O_ACK(O_ACK)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] prod;
    int          cap;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns two negedges later.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input bit push);
    exp_t e;
    I_DAT_A = a;
    I_DAT_B = b;
    I_STB   = 1'b1;
    @(negedge CLK);
    chk("i_ack_pulse", {63'b0, I_ACK}, 64'd1);
    if (push) begin
      e.prod = exp;
      e.cap  = cyc;
      sb.push_back(e);
    end
    I_STB   = 1'b0;
    I_DAT_A = 16'($urandom);
    I_DAT_B = 16'($urandom);
    @(negedge CLK);
    chk("i_ack_low", {63'b0, I_ACK}, 64'd0);
  endtask

  task automatic wait_ostb();
    int k = 0;
    while (!O_STB && k < 60) begin
      @(negedge CLK);
      k++;
    end
    chk("o_stb_seen", {63'b0, O_STB}, 64'd1);
  endtask

  task automatic run_ack_high(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    O_ACK = 1'b1;
    issue(a, b, exp, 1'b1);
    wait_ostb();
    @(negedge CLK);
    chk("o_stb_one_cycle", {63'b0, O_STB}, 64'd0);
  endtask

  // Monitor: pops on each rising O_STB, then checks O_DAT stays put while O_STB holds.
  logic        seen = 1'b0;
  logic [31:0] cur  = '0;
  exp_t        me;
  always @(negedge CLK) begin
    if (RST) begin
      seen = 1'b0;
    end else begin
      if (O_STB && !seen) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: got %0h expected no result", O_DAT);
        end else begin
          me = sb.pop_front();
          chk("product", {32'b0, O_DAT}, {32'b0, me.prod});
          chk("latency", 64'(cyc - me.cap), 64'(BW + 1));
          cur = me.prod;
        end
      end else if (O_STB) begin
        chk("o_dat_hold", {32'b0, O_DAT}, {32'b0, cur});
      end
      seen = O_STB;
    end
  end

  initial begin
    exp_t e;
    int k;
    RST = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      chk("rst_i_ack", {63'b0, I_ACK}, 64'd0);
      chk("rst_o_stb", {63'b0, O_STB}, 64'd0);
      chk("rst_o_dat", {32'b0, O_DAT}, 64'd0);
    end
    RST = 1'b0;

    // 511*63 with the consumer stalling, then acknowledging
    O_ACK = 1'b0;
    issue(16'd511, 16'd63, 32'd32193, 1'b1);
    wait_ostb();
    repeat (3) begin
      @(negedge CLK);
      chk("o_stb_held", {63'b0, O_STB}, 64'd1);
    end
    O_ACK = 1'b1;
    @(negedge CLK);
    chk("o_ack_clears", {63'b0, O_STB}, 64'd0);
    O_ACK = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      chk("o_dat_retained", {32'b0, O_DAT}, 64'd32193);
    end

    run_ack_high(16'd512, 16'd64, 32'd32768);
    run_ack_high(16'hFFFF, 16'hFFFF, EXP_FF);
    run_ack_high(16'd0, 16'd12345, 32'd0);

    // I_STB high during the acknowledge edge is only taken one edge later
    O_ACK = 1'b0;
    issue(16'd1000, 16'd1000, 32'd1000000, 1'b1);
    wait_ostb();
    I_DAT_A = 16'd7;
    I_DAT_B = 16'd9;
    I_STB   = 1'b1;
    O_ACK   = 1'b1;
    @(negedge CLK);
    chk("no_accept_in_ack", {63'b0, I_ACK}, 64'd0);
    chk("ack_cycle_o_stb", {63'b0, O_STB}, 64'd0);
    @(negedge CLK);
    chk("accept_after_ack", {63'b0, I_ACK}, 64'd1);
    e.prod = 32'd63;
    e.cap  = cyc;
    sb.push_back(e);
    I_STB = 1'b0;
    wait_ostb();
    @(negedge CLK);

    // Abort mid-BUSY, then accept on the first edge out of reset
    O_ACK = 1'b1;
    issue(16'd100, 16'd100, 32'd10000, 1'b0);
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_o_stb", {63'b0, O_STB}, 64'd0);
    chk("abort_i_ack", {63'b0, I_ACK}, 64'd0);
    chk("abort_o_dat", {32'b0, O_DAT}, 64'd0);
    RST = 1'b0;
    run_ack_high(16'd3, 16'd5, 32'd15);
    repeat (20) @(negedge CLK);

    run_ack_high(16'hFFFD, 16'd7, EXP_NEG);

    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge CLK);
      k++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no end of test expected completion");
    $fatal(1, "timeout");
  end

endmodule
